// File: rtl/baby_beat_sequencer.sv
// baby_beat_sequencer: four-beat timing chain (SCAN1, ACTION1, SCAN2, ACTION2).
// Each beat is DIGITS dash periods of digit phase followed by BLACKOUT dash
// periods of blackout. Handles run/stop, stop-instruction halting and, when
// BABY_BEAT_SEQ_SINGLE_STEP_EN is defined, single-instruction stepping.
// All outputs come straight from registers or a decode of the state register.

module baby_beat_sequencer #(
   parameter int DIGITS   = 32,
   parameter int BLACKOUT = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        dash_en,
   input  logic                        run,
   input  logic                        halt_req,
   input  logic                        step,
   output logic [1:0]                  stage,
   output logic [$clog2(DIGITS)-1:0]   digit,
   output logic                        blackout,
   output logic                        beat_start,
   output logic                        beat_end,
   output logic                        running,
   output logic                        halted
);

   localparam int DW = $clog2(DIGITS);
   localparam int BW = (BLACKOUT > 1) ? $clog2(BLACKOUT) : 1;
   localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);
   localparam logic [BW-1:0] BO_LAST    = BW'(BLACKOUT - 1);
   localparam logic [1:0]    STAGE_ACTION2 = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DIGIT    = 2'd1,
      ST_BLACKOUT = 2'd2
   } state_t;

   state_t          r_state, w_state_nx;
   logic [1:0]      r_stage, w_stage_nx;
   logic [DW-1:0]   r_digit, w_digit_nx;
   logic [BW-1:0]   r_bo_cnt, w_bo_cnt_nx;
   logic            r_beat_start, w_beat_start_nx;
   logic            r_beat_end, w_beat_end_nx;
   logic            r_halted, w_halted_nx;
   logic            r_halt_latch, w_halt_latch_nx;
   logic            r_run_low_seen, w_run_low_seen_nx;
   logic            r_step_armed, w_step_armed_nx;
   logic            r_step_mode, w_step_mode_nx;
   logic            w_stop;

`ifndef BABY_BEAT_SEQ_SINGLE_STEP_EN
   // Without the step feature the step input has no function.
   logic w_unused_step;
   assign w_unused_step = step;
`endif

   // Instruction-boundary stop decision: run off, halt pending, or a step done.
   assign w_stop = !run || r_halt_latch || halt_req || r_step_mode;

   // Next-state and next-output logic for the beat sequencer.
   always_comb begin
      // NOTE: every variable gets a default before the case so no latch is inferred.
      w_state_nx        = r_state;
      w_stage_nx        = r_stage;
      w_digit_nx        = r_digit;
      w_bo_cnt_nx       = r_bo_cnt;
      w_beat_start_nx   = 1'b0;
      w_beat_end_nx     = 1'b0;
      w_halted_nx       = r_halted;
      w_halt_latch_nx   = r_halt_latch;
      w_run_low_seen_nx = r_run_low_seen;
      w_step_armed_nx   = r_step_armed;
      w_step_mode_nx    = r_step_mode;

      case (r_state)
         ST_IDLE: begin
            if (r_halted) begin
               // Restart after a halt needs run seen low, then high again.
               if (!run) begin
                  w_run_low_seen_nx = 1'b1;
               end else if (r_run_low_seen) begin
                  w_halted_nx       = 1'b0;
                  w_run_low_seen_nx = 1'b0;
               end
            end else if (dash_en && (run || r_step_armed)) begin
               w_state_nx      = ST_DIGIT;
               w_stage_nx      = 2'd0;
               w_digit_nx      = '0;
               w_bo_cnt_nx     = '0;
               w_beat_start_nx = 1'b1;
               // run high at start wins over a pending step: normal run.
               w_step_mode_nx  = !run;
               w_step_armed_nx = 1'b0;
            end
`ifdef BABY_BEAT_SEQ_SINGLE_STEP_EN
            else if (step && !run) begin
               w_step_armed_nx = 1'b1;
            end
`endif
         end

         ST_DIGIT: begin
            if (halt_req) w_halt_latch_nx = 1'b1;
            if (dash_en) begin
               if (r_digit == DIGIT_LAST) begin
                  w_state_nx  = ST_BLACKOUT;
                  w_bo_cnt_nx = '0;
               end else begin
                  w_digit_nx = r_digit + DW'(1);
               end
            end
         end

         ST_BLACKOUT: begin
            if (halt_req) w_halt_latch_nx = 1'b1;
            if (dash_en) begin
               if (r_bo_cnt == BO_LAST) begin
                  w_beat_end_nx = 1'b1;
                  w_digit_nx    = '0;
                  w_bo_cnt_nx   = '0;
                  if (r_stage == STAGE_ACTION2 && w_stop) begin
                     w_state_nx        = ST_IDLE;
                     w_stage_nx        = 2'd0;
                     w_halted_nx       = r_halt_latch || halt_req;
                     w_halt_latch_nx   = 1'b0;
                     w_step_mode_nx    = 1'b0;
                     w_run_low_seen_nx = 1'b0;
                  end else begin
                     w_state_nx      = ST_DIGIT;
                     w_stage_nx      = r_stage + 2'd1;
                     w_beat_start_nx = 1'b1;
                  end
               end else begin
                  w_bo_cnt_nx = r_bo_cnt + BW'(1);
               end
            end
         end

         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   // State register with synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) begin
         r_state        <= ST_IDLE;
         r_stage        <= 2'd0;
         r_digit        <= '0;
         r_bo_cnt       <= '0;
         r_beat_start   <= 1'b0;
         r_beat_end     <= 1'b0;
         r_halted       <= 1'b0;
         r_halt_latch   <= 1'b0;
         r_run_low_seen <= 1'b0;
         r_step_armed   <= 1'b0;
         r_step_mode    <= 1'b0;
      end else begin
         r_state        <= w_state_nx;
         r_stage        <= w_stage_nx;
         r_digit        <= w_digit_nx;
         r_bo_cnt       <= w_bo_cnt_nx;
         r_beat_start   <= w_beat_start_nx;
         r_beat_end     <= w_beat_end_nx;
         r_halted       <= w_halted_nx;
         r_halt_latch   <= w_halt_latch_nx;
         r_run_low_seen <= w_run_low_seen_nx;
         r_step_armed   <= w_step_armed_nx;
         r_step_mode    <= w_step_mode_nx;
      end
   end

   assign stage      = r_stage;
   assign digit      = r_digit;
   assign blackout   = (r_state == ST_BLACKOUT);
   assign running    = (r_state != ST_IDLE);
   assign beat_start = r_beat_start;
   assign beat_end   = r_beat_end;
   assign halted     = r_halted;

endmodule

// File: tb/tb_baby_beat_sequencer.sv
// Self-checking bench for baby_beat_sequencer with DIGITS=4, BLACKOUT=2.
// A vector table covers reset and a full four-beat instruction with dash_en
// every clk; hand-written sequences cover stop, halt, step, reset and
// sparse dash_en.

module tb_baby_beat_sequencer;

   logic       clk = 1'b0;
   logic       reset, dash_en, run, halt_req, step;
   logic [1:0] stage;
   logic [1:0] digit;
   logic       blackout, beat_start, beat_end, running, halted;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       dash, run, halt, stp, rst;
      logic [1:0] stage, digit;
      logic       bo, bs, be, running, halted;
   } vec_t;

   vec_t vecs[$];

   baby_beat_sequencer #(.DIGITS(4), .BLACKOUT(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .dash_en    (dash_en),
      .run        (run),
      .halt_req   (halt_req),
      .step       (step),
      .stage      (stage),
      .digit      (digit),
      .blackout   (blackout),
      .beat_start (beat_start),
      .beat_end   (beat_end),
      .running    (running),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive inputs away from the edge, then sample 1 time unit after it.
   task automatic tick(input int d, input int r, input int h, input int s, input int rst);
      dash_en  = (d != 0);
      run      = (r != 0);
      halt_req = (h != 0);
      step     = (s != 0);
      reset    = (rst != 0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string name, input int st, input int dg, input int bo,
                            input int bs, input int be, input int rn, input int hl);
      check({name, ".stage"},      int'(stage),      st);
      check({name, ".digit"},      int'(digit),      dg);
      check({name, ".blackout"},   int'(blackout),   bo);
      check({name, ".beat_start"}, int'(beat_start), bs);
      check({name, ".beat_end"},   int'(beat_end),   be);
      check({name, ".running"},    int'(running),    rn);
      check({name, ".halted"},     int'(halted),     hl);
   endtask

   function automatic vec_t mk(input int d, input int r, input int h, input int s, input int rst,
                               input int st, input int dg, input int bo, input int bs,
                               input int be, input int rn, input int hl);
      vec_t v;
      v.dash = (d != 0);   v.run = (r != 0);   v.halt = (h != 0);
      v.stp  = (s != 0);   v.rst = (rst != 0);
      v.stage = 2'(st);    v.digit = 2'(dg);   v.bo = (bo != 0);
      v.bs = (bs != 0);    v.be = (be != 0);   v.running = (rn != 0);
      v.halted = (hl != 0);
      return v;
   endfunction

   task automatic start_run();
      tick(0, 0, 0, 0, 1);
      tick(1, 1, 0, 0, 0);
   endtask

   initial begin
      int dig_pat[5];
      int bo_pat[5];
      int n, stop_n, bs_cnt, nd;
      bit seen_run;

      dig_pat = '{1, 2, 3, 3, 3};
      bo_pat  = '{0, 0, 0, 1, 1};
      reset = 1'b1; dash_en = 1'b0; run = 1'b0; halt_req = 1'b0; step = 1'b0;

      // ---------------- vector table: reset + full instruction ----------------
      vecs.push_back(mk(0,0,0,0,1, 0,0,0,0,0,0,0));
      vecs.push_back(mk(1,1,0,0,0, 0,0,0,1,0,1,0));
      for (int b = 0; b < 4; b++) begin
         for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1,1,0,0,0, b, dig_pat[k], bo_pat[k], 0,0,1,0));
         vecs.push_back(mk(1,1,0,0,0, (b+1)%4, 0,0, 1,1,1,0));
      end
      foreach (vecs[i]) begin
         tick(int'(vecs[i].dash), int'(vecs[i].run), int'(vecs[i].halt),
              int'(vecs[i].stp), int'(vecs[i].rst));
         check_all($sformatf("vec%0d", i), int'(vecs[i].stage), int'(vecs[i].digit),
                   int'(vecs[i].bo), int'(vecs[i].bs), int'(vecs[i].be),
                   int'(vecs[i].running), int'(vecs[i].halted));
      end

      // ---------------- run cleared mid SCAN2 ----------------
      start_run();
      for (int i = 0; i < 14; i++) tick(1, 1, 0, 0, 0);
      check("stop.pre_stage", int'(stage), 2);
      check("stop.pre_digit", int'(digit), 2);
      stop_n = 0; bs_cnt = 0;
      for (int i = 1; i <= 30; i++) begin
         tick(1, 0, 0, 0, 0);
         if (beat_start && stage == 2'd3) bs_cnt++;
         if (!running) begin stop_n = i; break; end
      end
      check("stop.clks", stop_n, 10);
      check("stop.action2_beats", bs_cnt, 1);
      check_all("stop.end", 0, 0, 0, 0, 1, 0, 0);
      tick(1, 0, 0, 0, 0);
      check("stop.beat_end_once", int'(beat_end), 0);
      check("stop.no_start", int'(running), 0);

      // ---------------- halt_req in ACTION1 ----------------
      start_run();
      for (int i = 0; i < 6; i++) tick(1, 1, 0, 0, 0);
      check("halt.in_action1", int'(stage), 1);
      tick(1, 1, 1, 0, 0);
      stop_n = 0; bs_cnt = 0;
      for (int i = 1; i <= 30; i++) begin
         tick(1, 1, 0, 0, 0);
         if (beat_start) bs_cnt++;
         if (!running) begin stop_n = i; break; end
      end
      check("halt.clks", stop_n, 17);
      check("halt.beats_after", bs_cnt, 2);
      check_all("halt.end", 0, 0, 0, 0, 1, 0, 1);
      seen_run = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick(1, 1, 0, 0, 0);
         if (running) seen_run = 1'b1;
      end
      check("halt.run_held_no_restart", int'(seen_run), 0);
      check("halt.still_halted", int'(halted), 1);
      tick(0, 0, 0, 0, 0);
      check("halt.run_low_keeps_halted", int'(halted), 1);
      tick(0, 1, 0, 0, 0);
      check("halt.cleared", int'(halted), 0);
      check("halt.not_yet_running", int'(running), 0);
      tick(1, 1, 0, 0, 0);
      check_all("halt.restart", 0, 0, 0, 1, 0, 1, 0);

      // ---------------- single-step ----------------
      tick(0, 0, 0, 0, 1);
`ifdef BABY_BEAT_SEQ_SINGLE_STEP_EN
      for (int rep = 0; rep < 2; rep++) begin
         tick(0, 0, 0, 1, 0);
         check($sformatf("step%0d.armed_idle", rep), int'(running), 0);
         tick(1, 0, 0, 0, 0);
         check_all($sformatf("step%0d.start", rep), 0, 0, 0, 1, 0, 1, 0);
         bs_cnt = 1;
         for (int i = 0; i < 30; i++) begin
            tick(1, 0, 0, 0, 0);
            if (!running) break;
            if (beat_start) begin
               check($sformatf("step%0d.stage_order", rep), int'(stage), bs_cnt);
               bs_cnt++;
            end
         end
         check($sformatf("step%0d.beats", rep), bs_cnt, 4);
         check($sformatf("step%0d.stopped", rep), int'(running), 0);
         check($sformatf("step%0d.not_halted", rep), int'(halted), 0);
      end
`else
      seen_run = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(1, 0, 0, 1, 0);
         if (running) seen_run = 1'b1;
      end
      check("step.ignored", int'(seen_run), 0);
`endif

      // ---------------- reset mid ACTION1 ----------------
      start_run();
      for (int i = 0; i < 8; i++) tick(1, 1, 0, 0, 0);
      check("rst.pre_stage", int'(stage), 1);
      check("rst.pre_digit", int'(digit), 2);
      tick(1, 1, 0, 0, 1);
      check_all("rst.values", 0, 0, 0, 0, 0, 0, 0);
      seen_run = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(1, 0, 0, 0, 0);
         if (running) seen_run = 1'b1;
      end
      check("rst.dash_alone_no_start", int'(seen_run), 0);

      // ---------------- dash_en every 3rd clk ----------------
      start_run();
      check_all("sparse.start", 0, 0, 0, 1, 0, 1, 0);
      nd = 0;
      for (n = 1; n <= 18; n++) begin
         tick(((n % 3) == 0) ? 1 : 0, 1, 0, 0, 0);
         if ((n % 3) == 0) nd++;
         if (n < 18) begin
            check($sformatf("sparse%0d.digit", n), int'(digit), (nd < 3) ? nd : 3);
            check($sformatf("sparse%0d.blackout", n), int'(blackout), (nd >= 4) ? 1 : 0);
            check($sformatf("sparse%0d.beat_start", n), int'(beat_start), 0);
            check($sformatf("sparse%0d.beat_end", n), int'(beat_end), 0);
         end
      end
      check_all("sparse.boundary", 1, 0, 0, 1, 1, 1, 0);
      tick(0, 1, 0, 0, 0);
      check("sparse.bs_single", int'(beat_start), 0);
      check("sparse.be_single", int'(beat_end), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
